// File: rtl/ysyx_24110015_csr_unit.sv
// Machine-mode CSR unit: address-decoded CSRRW/RS/RC port, trap entry, mret
// return, and free-running 64-bit mcycle/minstret counters.
module ysyx_24110015_csr_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'('h1800),
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter logic [31:0]     MVENDORID   = 32'h7973_7978,
  parameter logic [31:0]     MARCHID     = 32'd24110015
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret,
  input  logic            retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [63:0]     mcycle;
  logic [63:0]     minstret;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] wnew;
  logic            hit;
  logic            is_ro;
  logic            wr_req;
  logic            csr_we;
  logic [63:0]     mcycle_nxt;
  logic [63:0]     minstret_nxt;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored.
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie;
    mstatus_val[3]     = mie;
  end

  always_comb begin
    rd_val = '0;
    hit    = 1'b1;
    is_ro  = 1'b0;
    case (csr_addr)
      ADDR_MSTATUS:   rd_val = mstatus_val;
      ADDR_MTVEC:     rd_val = mtvec;
      ADDR_MSCRATCH:  rd_val = mscratch;
      ADDR_MEPC:      rd_val = mepc;
      ADDR_MCAUSE:    rd_val = mcause;
      ADDR_MCYCLE:    rd_val = mcycle[XLEN-1:0];
      ADDR_MINSTRET:  rd_val = minstret[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) rd_val = XLEN'(mcycle[63:32]);
        else            hit    = 1'b0;
      end
      ADDR_MINSTRETH: begin
        if (XLEN == 32) rd_val = XLEN'(minstret[63:32]);
        else            hit    = 1'b0;
      end
      ADDR_MVENDORID: begin
        rd_val = XLEN'(MVENDORID);
        is_ro  = 1'b1;
      end
      ADDR_MARCHID: begin
        rd_val = XLEN'(MARCHID);
        is_ro  = 1'b1;
      end
      default:        hit = 1'b0;
    endcase
  end

  // RS/RC with a zero mask are pure reads, so they stay legal on read-only CSRs.
  assign wr_req      = (csr_op == OP_RW) |
                       (((csr_op == OP_RS) | (csr_op == OP_RC)) & (|csr_wdata));
  assign csr_illegal = csr_valid & (~hit | (is_ro & wr_req));
  assign csr_rdata   = csr_illegal ? '0 : rd_val;
  assign csr_we      = csr_valid & wr_req & ~csr_illegal & ~exc_valid & ~mret;

  always_comb begin
    case (csr_op)
      OP_RW:   wnew = csr_wdata;
      OP_RS:   wnew = rd_val | csr_wdata;
      OP_RC:   wnew = rd_val & ~csr_wdata;
      default: wnew = rd_val;
    endcase
  end

  always_comb begin
    mcycle_nxt = mcycle + 64'd1;
    if (csr_we && csr_addr == ADDR_MCYCLE)
      mcycle_nxt = (XLEN == 64) ? 64'(wnew) : {mcycle[63:32], wnew[31:0]};
    else if (csr_we && csr_addr == ADDR_MCYCLEH)
      mcycle_nxt = {wnew[31:0], mcycle[31:0]};

    minstret_nxt = retire ? minstret + 64'd1 : minstret;
    if (csr_we && csr_addr == ADDR_MINSTRET)
      minstret_nxt = (XLEN == 64) ? 64'(wnew) : {minstret[63:32], wnew[31:0]};
    else if (csr_we && csr_addr == ADDR_MINSTRETH)
      minstret_nxt = {wnew[31:0], minstret[31:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie      <= MSTATUS_RST[3];
      mpie     <= MSTATUS_RST[7];
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
      if (exc_valid) begin
        mepc   <= exc_pc & ALIGN_MASK;
        mcause <= exc_cause;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (mret) begin
        mie    <= mpie;
        mpie   <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mie  <= wnew[3];
            mpie <= wnew[7];
          end
          ADDR_MTVEC:    mtvec    <= wnew & ALIGN_MASK;
          ADDR_MSCRATCH: mscratch <= wnew;
          ADDR_MEPC:     mepc     <= wnew & ALIGN_MASK;
          ADDR_MCAUSE:   mcause   <= wnew;
          default: ;
        endcase
      end
    end
  end

  assign redirect_valid = exc_valid | mret;
  assign redirect_pc    = exc_valid ? mtvec : (mret ? mepc : '0);

endmodule

// File: tb/tb_ysyx_24110015_csr_unit.sv
// Directed bench for ysyx_24110015_csr_unit (XLEN=32): CSR ops, trap/mret,
// event priority, illegal access, counter write/wrap and async reset.
module tb_ysyx_24110015_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic        mret;
  logic        retire;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_24110015_csr_unit dut (
    .clk            (clk),
    .rst            (rst),
    .csr_valid      (csr_valid),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .mret           (mret),
    .retire         (retire),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one CSR access for exactly one rising edge; outputs are sampled
  // 2ns after the falling edge, well before the committing edge.
  task automatic drive_csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    @(negedge clk);
    csr_valid = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    exc_valid = 1'b0;
    mret      = 1'b0;
    #2;
  endtask

  task automatic go_idle();
    @(negedge clk);
    csr_valid = 1'b0;
    csr_op    = 2'b00;
    csr_addr  = 12'h000;
    csr_wdata = '0;
    exc_valid = 1'b0;
    exc_cause = '0;
    exc_pc    = '0;
    mret      = 1'b0;
    retire    = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    csr_valid = 1'b0;
    csr_op    = 2'b00;
    csr_addr  = 12'h000;
    csr_wdata = '0;
    exc_valid = 1'b0;
    exc_cause = '0;
    exc_pc    = '0;
    mret      = 1'b0;
    retire    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_redirect_valid", redirect_valid, 0);
    check_val("rst_redirect_pc", redirect_pc, 0);
    csr_valid = 1'b1; csr_addr = 12'h300; #1;
    check_val("rst_mstatus", csr_rdata, 32'h1800);
    csr_addr = 12'hB00; #1;
    check_val("rst_mcycle", csr_rdata, 0);

    // Release on a falling edge: five rising edges later mcycle == 5.
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_val("mcycle_at_release", csr_rdata, 0);
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    check_val("mcycle_after_5", csr_rdata, 5);
    @(negedge clk); #2;
    check_val("mcycle_after_6", csr_rdata, 6);

    drive_csr(2'b01, 12'h305, 32'h8000_0007);
    check_val("mtvec_rw_old", csr_rdata, 0);
    check_val("mtvec_rw_illegal", csr_illegal, 0);
    drive_csr(2'b00, 12'h305, 0);
    check_val("mtvec_aligned", csr_rdata, 32'h8000_0004);
    drive_csr(2'b01, 12'h340, 32'h0F);
    check_val("mscratch_rw_old", csr_rdata, 0);
    drive_csr(2'b10, 12'h340, 32'hF0);
    check_val("mscratch_rs_old", csr_rdata, 32'h0F);
    drive_csr(2'b11, 12'h340, 32'h0F);
    check_val("mscratch_rc_old", csr_rdata, 32'hFF);
    drive_csr(2'b00, 12'h340, 0);
    check_val("mscratch_after_rc", csr_rdata, 32'hF0);

    // Trap with a same-cycle mepc read: read returns the old mepc.
    drive_csr(2'b01, 12'h300, 32'h1808);
    check_val("mstatus_rw_old", csr_rdata, 32'h1800);
    @(negedge clk);
    csr_op = 2'b00; csr_addr = 12'h341; csr_wdata = '0;
    exc_valid = 1'b1; exc_pc = 32'h8000_0010; exc_cause = 32'd11;
    #2;
    check_val("trap_redirect_valid", redirect_valid, 1);
    check_val("trap_redirect_pc", redirect_pc, 32'h8000_0004);
    check_val("trap_old_mepc", csr_rdata, 0);
    drive_csr(2'b00, 12'h300, 0);
    check_val("trap_mstatus", csr_rdata, 32'h1880);
    drive_csr(2'b00, 12'h341, 0);
    check_val("trap_mepc", csr_rdata, 32'h8000_0010);
    drive_csr(2'b00, 12'h342, 0);
    check_val("trap_mcause", csr_rdata, 11);

    @(negedge clk);
    csr_valid = 1'b0; mret = 1'b1;
    #2;
    check_val("mret_redirect_valid", redirect_valid, 1);
    check_val("mret_redirect_pc", redirect_pc, 32'h8000_0010);
    drive_csr(2'b00, 12'h300, 0);
    check_val("mret_mstatus", csr_rdata, 32'h1888);

    // Trap + mret + CSRRW together: only the trap takes effect.
    @(negedge clk);
    csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234;
    exc_valid = 1'b1; exc_pc = 32'h8000_0023; exc_cause = 32'd2; mret = 1'b1;
    #2;
    check_val("prio_redirect_pc", redirect_pc, 32'h8000_0004);
    drive_csr(2'b00, 12'h340, 0);
    check_val("prio_mscratch_kept", csr_rdata, 32'hF0);
    drive_csr(2'b00, 12'h341, 0);
    check_val("prio_mepc", csr_rdata, 32'h8000_0020);
    drive_csr(2'b00, 12'h342, 0);
    check_val("prio_mcause", csr_rdata, 2);
    drive_csr(2'b00, 12'h300, 0);
    check_val("prio_mstatus", csr_rdata, 32'h1880);

    drive_csr(2'b01, 12'hB00, 32'd5);
    drive_csr(2'b00, 12'hB00, 0);
    check_val("mcycle_written", csr_rdata, 5);
    drive_csr(2'b00, 12'hB00, 0);
    check_val("mcycle_resume", csr_rdata, 6);

    drive_csr(2'b01, 12'hF11, 32'hDEAD);
    check_val("ro_write_illegal", csr_illegal, 1);
    check_val("ro_write_rdata", csr_rdata, 0);
    drive_csr(2'b10, 12'hF11, 0);
    check_val("ro_rs0_illegal", csr_illegal, 0);
    check_val("ro_rs0_rdata", csr_rdata, 32'h7973_7978);
    drive_csr(2'b11, 12'hF12, 0);
    check_val("marchid_rc0", csr_rdata, 32'd24110015);
    drive_csr(2'b00, 12'h7C0, 0);
    check_val("unimpl_illegal", csr_illegal, 1);
    csr_valid = 1'b0; #1;
    check_val("unimpl_not_valid", csr_illegal, 0);
    drive_csr(2'b01, 12'h7C0, 32'h55);
    check_val("unimpl_rdata", csr_rdata, 0);

    go_idle();
    retire = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    retire = 1'b0;
    drive_csr(2'b00, 12'hB02, 0);
    check_val("minstret_3", csr_rdata, 3);
    drive_csr(2'b01, 12'hB82, 32'h0000_0007);
    drive_csr(2'b00, 12'hB82, 0);
    check_val("minstreth_written", csr_rdata, 7);
    drive_csr(2'b00, 12'hB02, 0);
    check_val("minstret_low_held", csr_rdata, 3);

    // 64-bit wrap of mcycle.
    drive_csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    drive_csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    drive_csr(2'b00, 12'hB80, 0);
    check_val("wrap_high_pre", csr_rdata, 32'hFFFF_FFFF);
    drive_csr(2'b00, 12'hB00, 0);
    check_val("wrap_low", csr_rdata, 0);
    drive_csr(2'b00, 12'hB80, 0);
    check_val("wrap_high", csr_rdata, 0);

    // Asynchronous reset mid-count takes effect without a clock edge.
    go_idle();
    #1;
    rst = 1'b0;
    csr_valid = 1'b1; csr_addr = 12'hB00; #1;
    check_val("async_rst_mcycle", csr_rdata, 0);
    csr_addr = 12'h340; #1;
    check_val("async_rst_mscratch", csr_rdata, 0);
    csr_addr = 12'h305; #1;
    check_val("async_rst_mtvec", csr_rdata, 0);
    csr_addr = 12'h300; #1;
    check_val("async_rst_mstatus", csr_rdata, 32'h1800);

    go_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
